// File: rtl/fp16_pkg.sv
// Shared FP16 field constants and the converter state encoding.
package fp16_pkg;

  localparam int unsigned FP16_EXP_BIAS = 15;
  localparam logic [4:0]  FP16_EXP_INF  = 5'h1F;
  localparam int unsigned FP16_EXP_W    = 5;
  localparam int unsigned FP16_MAN_W    = 10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    NORM = 2'd1,
    PACK = 2'd2
  } state_t;

endpackage

// File: rtl/fp16_pack.sv
// Combinational packer: normalised magnitude plus shift count to an FP16 word.
module fp16_pack
  import fp16_pkg::*;
#(
  parameter  int unsigned IN_W   = 16,
  parameter  int unsigned FRAC_W = 8,
  localparam int unsigned K_W    = $clog2(IN_W)
) (
  input  logic            sign,
  input  logic [IN_W-1:0] mag,
  input  logic [K_W-1:0]  k,
  output logic [15:0]     res,
  output logic            overflow
);

  localparam int E_OFS = int'(FP16_EXP_BIAS) + int'(IN_W) - 1 - int'(FRAC_W);

  logic signed [7:0]      e;
  logic [FP16_MAN_W-1:0]  man;

  always_comb begin
    e        = 8'(E_OFS) - 8'(k);
    man      = mag[IN_W-2 -: FP16_MAN_W];
    res      = 16'h0000;
    overflow = 1'b0;
    // Zero wins over sign; exponents outside 1..30 saturate or flush.
    if (mag == '0) begin
      res = 16'h0000;
    end else if (e > 8'sd30) begin
      res      = {sign, FP16_EXP_INF, 10'h000};
      overflow = 1'b1;
    end else if (e < 8'sd1) begin
      res = {sign, 15'h0000};
    end else begin
      res = {sign, e[FP16_EXP_W-1:0], man};
    end
  end

endmodule

// File: rtl/fixed_to_fp16_seq.sv
// Sequential fixed-point to FP16 converter; normalises one bit per cycle.
module fixed_to_fp16_seq
  import fp16_pkg::*;
#(
  parameter int unsigned IN_W   = 16,
  parameter int unsigned FRAC_W = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [IN_W-1:0] i_data,
  input  logic            i_vld,
  output logic            o_rdy,
  output logic [15:0]     o_res,
  output logic            o_res_vld,
  output logic            overflow
);

  localparam int unsigned K_W = $clog2(IN_W);

  state_t          state;
  logic            sign;
  logic [IN_W-1:0] mag;
  logic [K_W-1:0]  k;
  logic [15:0]     pack_res;
  logic            pack_ovf;

  assign o_rdy = (state == IDLE);

  fp16_pack #(
    .IN_W   (IN_W),
    .FRAC_W (FRAC_W)
  ) u_pack (
    .sign     (sign),
    .mag      (mag),
    .k        (k),
    .res      (pack_res),
    .overflow (pack_ovf)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      sign      <= 1'b0;
      mag       <= '0;
      k         <= '0;
      o_res     <= 16'h0000;
      o_res_vld <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      o_res_vld <= 1'b0;
      case (state)
        IDLE: begin
          if (i_vld) begin
            // Most negative input negates onto itself: 1 followed by zeros.
            sign  <= i_data[IN_W-1];
            mag   <= i_data[IN_W-1] ? (~i_data + IN_W'(1)) : i_data;
            k     <= '0;
            state <= NORM;
          end
        end
        NORM: begin
          if (mag == '0 || mag[IN_W-1]) begin
            state <= PACK;
          end else begin
            mag <= mag << 1;
            k   <= k + K_W'(1);
          end
        end
        PACK: begin
          o_res     <= pack_res;
          overflow  <= pack_ovf;
          o_res_vld <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fixed_to_fp16_seq.sv
// Scoreboard bench: 16-bit/Q8 and 32-bit/Q0 converters driven with directed vectors.
module tb_fixed_to_fp16_seq;

  typedef struct {
    logic [15:0] res;
    logic        ovf;
    int          acc;
    int          lat;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] d16;
  logic        v16, rdy16, vld16, ovf16;
  logic [15:0] res16;
  logic [31:0] d32;
  logic        v32, rdy32, vld32, ovf32;
  logic [15:0] res32;

  exp_t q16[$];
  exp_t q32[$];
  exp_t m16, m32;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  fixed_to_fp16_seq #(.IN_W(16), .FRAC_W(8)) dut16 (
    .clk(clk), .rst(rst), .i_data(d16), .i_vld(v16),
    .o_rdy(rdy16), .o_res(res16), .o_res_vld(vld16), .overflow(ovf16)
  );

  fixed_to_fp16_seq #(.IN_W(32), .FRAC_W(0)) dut32 (
    .clk(clk), .rst(rst), .i_data(d32), .i_vld(v32),
    .o_rdy(rdy32), .o_res(res32), .o_res_vld(vld32), .overflow(ovf32)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Monitors: pop and compare whenever a converter presents a result.
  always @(negedge clk) begin
    if (!rst && vld16) begin
      if (q16.size() == 0) begin
        chk("unexpected_vld16", 32'(vld16), 32'(0));
      end else begin
        m16 = q16.pop_front();
        chk("res16", 32'(res16), 32'(m16.res));
        chk("ovf16", 32'(ovf16), 32'(m16.ovf));
        chk("lat16", 32'(cyc - m16.acc), 32'(m16.lat));
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && vld32) begin
      if (q32.size() == 0) begin
        chk("unexpected_vld32", 32'(vld32), 32'(0));
      end else begin
        m32 = q32.pop_front();
        chk("res32", 32'(res32), 32'(m32.res));
        chk("ovf32", 32'(ovf32), 32'(m32.ovf));
        chk("lat32", 32'(cyc - m32.acc), 32'(m32.lat));
      end
    end
  end

  task automatic send(input bit wide, input logic [31:0] d, input logic [15:0] r,
                      input logic o, input int lat);
    int   n;
    exp_t e;
    n = 0;
    @(negedge clk);
    while (!(wide ? rdy32 : rdy16) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) chk("rdy_timeout", 32'(0), 32'(1));
    e = '{r, o, cyc + 1, lat};
    if (wide) begin
      d32 = d;
      v32 = 1'b1;
      q32.push_back(e);
    end else begin
      d16 = d[15:0];
      v16 = 1'b1;
      q16.push_back(e);
    end
    @(posedge clk);
    #1;
    v16 = 1'b0;
    v32 = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q16.size() != 0 || q32.size() != 0) && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("drain_q16", 32'(q16.size()), 32'(0));
    chk("drain_q32", 32'(q32.size()), 32'(0));
  endtask

  logic [15:0] hs_d [4];
  logic [15:0] hs_r [4];
  int          hs_l [4];

  initial begin
    int next_acc;
    int j;
    rst = 1'b1;
    v16 = 1'b0; v32 = 1'b0;
    d16 = '0;   d32 = '0;
    hs_d = '{16'h8000, 16'h7FFF, 16'h0003, 16'h0100};
    hs_r = '{16'hD800, 16'h57FF, 16'h2200, 16'h3C00};
    hs_l = '{2, 3, 16, 9};

    repeat (2) @(negedge clk);
    chk("rst_rdy16", 32'(rdy16), 32'(1));
    chk("rst_res16", 32'(res16), 32'(0));
    chk("rst_vld16", 32'(vld16), 32'(0));
    chk("rst_ovf16", 32'(ovf16), 32'(0));
    chk("rst_rdy32", 32'(rdy32), 32'(1));
    chk("rst_res32", 32'(res32), 32'(0));
    rst = 1'b0;

    // 16-bit Q8 directed vectors
    send(1'b0, 32'h0100, 16'h3C00, 1'b0, 9);
    send(1'b0, 32'hFF00, 16'hBC00, 1'b0, 9);
    send(1'b0, 32'h8000, 16'hD800, 1'b0, 2);
    send(1'b0, 32'h0000, 16'h0000, 1'b0, 2);
    send(1'b0, 32'h0001, 16'h1C00, 1'b0, 17);
    send(1'b0, 32'h0003, 16'h2200, 1'b0, 16);
    send(1'b0, 32'h7FFF, 16'h57FF, 1'b0, 3);
    send(1'b0, 32'hFFFF, 16'h9C00, 1'b0, 17);

    // 32-bit Q0 vectors, including saturation
    send(1'b1, 32'h7FFFFFFF, 16'h7C00, 1'b1, 3);
    send(1'b1, 32'h80000000, 16'hFC00, 1'b1, 2);
    send(1'b1, 32'h00000001, 16'h3C00, 1'b0, 33);
    send(1'b1, 32'hFFFFFFFE, 16'hC000, 1'b0, 32);
    drain();

    // i_vld held high with data changing every cycle
    next_acc = 0;
    for (int t = 0; t < 60; t++) begin
      @(negedge clk);
      j = t % 4;
      v16 = 1'b1;
      d16 = hs_d[j];
      chk("hs_rdy", 32'(rdy16), 32'(t == next_acc));
      if (t == next_acc) begin
        q16.push_back('{hs_r[j], 1'b0, cyc + 1, hs_l[j]});
        next_acc = t + hs_l[j] + 1;
      end
    end
    @(negedge clk);
    v16 = 1'b0;
    drain();

    // reset in the middle of normalising 16'h0001
    send(1'b0, 32'h0001, 16'h1C00, 1'b0, 17);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    #1;
    q16.delete();
    chk("midrst_rdy", 32'(rdy16), 32'(1));
    chk("midrst_res", 32'(res16), 32'(0));
    chk("midrst_ovf", 32'(ovf16), 32'(0));
    chk("midrst_vld", 32'(vld16), 32'(0));
    @(negedge clk);
    rst = 1'b0;
    repeat (25) @(negedge clk);
    send(1'b0, 32'h0100, 16'h3C00, 1'b0, 9);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
